// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared CPU datapath types (word, RAM handshake, arbiter FSM)
// Revision      : 1.0
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        IOWN = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : beat-locked dcache/icache arbiter onto a single-ported RAM.
//               MEM_ARB_FAIR_EN adds an icache starvation limit.
// Revision    : 1.0
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = $bits(word_t),
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t         state;
    arb_state_t         next_state;
    logic               dreq;
    logic               beat_done;
    logic               d_sel;
    logic               i_sel;
    logic               fair_force;
    logic [CNT_W-1:0]   starve_cnt;

    assign dreq      = dREN | dWEN;
    assign beat_done = (ramstate == ACCESS);
    assign dload     = ramload;
    assign iload     = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        d_sel      = 1'b0;
        i_sel      = 1'b0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        dwait      = 1'b1;
        iwait      = 1'b1;

        // Owner selection; only IDLE arbitrates, the owned states are locked.
        case (state)
            IDLE: begin
                if (fair_force && iREN) begin
                    i_sel = 1'b1;
                end else if (dreq) begin
                    d_sel = 1'b1;
                end else if (iREN) begin
                    i_sel = 1'b1;
                end
            end
            DOWN:    d_sel = dreq;
            IOWN:    i_sel = iREN;
            default: ;
        endcase

        if (d_sel) begin
            ramWEN     = dWEN;
            ramREN     = dREN & ~dWEN;
            ramaddr    = daddr;
            ramstore   = dstore;
            dwait      = ~beat_done;
            next_state = beat_done ? IDLE : DOWN;
        end else if (i_sel) begin
            ramREN     = iREN;
            ramaddr    = iaddr;
            iwait      = ~beat_done;
            next_state = beat_done ? IDLE : IOWN;
        end
    end

`ifdef MEM_ARB_FAIR_EN
    // Counts dcache beats completed while the icache is kept waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (!iREN || (i_sel && beat_done)) begin
            starve_cnt <= '0;
        end else if (d_sel && beat_done && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starve_cnt = '0;
`endif

    assign fair_force = (starve_cnt == CNT_W'(STARVE_MAX));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : vector-table bench for mem_arbiter plus multi-cycle sequences
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr, ramload;
    logic [1:0]  ramstate;
    logic        dwait, iwait, ramREN, ramWEN;
    logic [31:0] dload, iload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        dr, dw, ir;
        logic [31:0] da, ds, ia;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_dwait, e_iwait;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic dr, dw, ir,
                                input logic [31:0] da, ds, ia,
                                input logic [1:0] rs, input logic [31:0] rl,
                                input logic er, ew, input logic [31:0] ea, es,
                                input logic edw, eiw);
        vec_t v;
        v.dr = dr; v.dw = dw; v.ir = ir; v.da = da; v.ds = ds; v.ia = ia;
        v.rs = rs; v.rl = rl; v.e_ren = er; v.e_wen = ew; v.e_addr = ea;
        v.e_store = es; v.e_dwait = edw; v.e_iwait = eiw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dr, dw, ir, input logic [31:0] da, ds, ia,
                         input logic [1:0] rs, input logic [31:0] rl);
        dREN = dr; dWEN = dw; iREN = ir; daddr = da; dstore = ds; iaddr = ia;
        ramstate = rs; ramload = rl;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ramREN"},   {31'd0, ramREN}, 32'd0);
        chk({tag, ".ramWEN"},   {31'd0, ramWEN}, 32'd0);
        chk({tag, ".ramaddr"},  ramaddr,  32'd0);
        chk({tag, ".ramstore"}, ramstore, 32'd0);
        chk({tag, ".dwait"},    {31'd0, dwait}, 32'd1);
        chk({tag, ".iwait"},    {31'd0, iwait}, 32'd1);
    endtask

    initial begin
        int icomp;
        int dcomp;
        logic exp_i;

        // dr dw ir  daddr   dstore   iaddr    ramstate ramload     | ren wen addr     store    dw iw
        vecs[0]  = mk(0,0,1'b0, 32'h0,  32'h0,    32'h0,  FREE,   32'h0,        0,0, 32'h0,  32'h0,    1,1);
        vecs[1]  = mk(0,0,1'b1, 32'h0,  32'h0,    32'h40, BUSY,   32'h0,        1,0, 32'h40, 32'h0,    1,1);
        vecs[2]  = mk(0,0,1'b1, 32'h0,  32'h0,    32'h40, BUSY,   32'h0,        1,0, 32'h40, 32'h0,    1,1);
        vecs[3]  = mk(0,0,1'b1, 32'h0,  32'h0,    32'h40, ACCESS, 32'hDEADBEEF, 1,0, 32'h40, 32'h0,    1,0);
        vecs[4]  = mk(1,0,1'b1, 32'h100,32'h0,    32'h0,  BUSY,   32'h0,        1,0, 32'h100,32'h0,    1,1);
        vecs[5]  = mk(1,0,1'b1, 32'h100,32'h0,    32'h0,  ACCESS, 32'h11111111, 1,0, 32'h100,32'h0,    0,1);
        vecs[6]  = mk(0,0,1'b1, 32'h100,32'h0,    32'h0,  BUSY,   32'h0,        1,0, 32'h0,  32'h0,    1,1);
        vecs[7]  = mk(0,0,1'b1, 32'h100,32'h0,    32'h0,  ACCESS, 32'h22222222, 1,0, 32'h0,  32'h0,    1,0);
        vecs[8]  = mk(0,0,1'b1, 32'h0,  32'h0,    32'h20, BUSY,   32'h0,        1,0, 32'h20, 32'h0,    1,1);
        vecs[9]  = mk(0,1,1'b1, 32'h8,  32'h1234, 32'h20, BUSY,   32'h0,        1,0, 32'h20, 32'h0,    1,1);
        vecs[10] = mk(0,1,1'b1, 32'h8,  32'h1234, 32'h20, ACCESS, 32'h33333333, 1,0, 32'h20, 32'h0,    1,0);
        vecs[11] = mk(0,1,1'b1, 32'h8,  32'h1234, 32'h20, BUSY,   32'h0,        0,1, 32'h8,  32'h1234, 1,1);
        vecs[12] = mk(0,1,1'b1, 32'h8,  32'h1234, 32'h20, ACCESS, 32'h0,        0,1, 32'h8,  32'h1234, 0,1);
        vecs[13] = mk(1,1,1'b0, 32'hC,  32'h55,   32'h0,  BUSY,   32'h0,        0,1, 32'hC,  32'h55,   1,1);
        vecs[14] = mk(1,1,1'b0, 32'hC,  32'h55,   32'h0,  ACCESS, 32'h0,        0,1, 32'hC,  32'h55,   0,1);
        vecs[15] = mk(1,0,1'b0, 32'h10, 32'h0,    32'h0,  BUSY,   32'h0,        1,0, 32'h10, 32'h0,    1,1);
        vecs[16] = mk(0,0,1'b0, 32'h10, 32'h0,    32'h0,  BUSY,   32'h0,        0,0, 32'h0,  32'h0,    1,1);
        vecs[17] = mk(0,0,1'b0, 32'h0,  32'h0,    32'h0,  ACCESS, 32'h44444444, 0,0, 32'h0,  32'h0,    1,1);
        vecs[18] = mk(0,0,1'b1, 32'h0,  32'h0,    32'h60, BUSY,   32'h0,        1,0, 32'h60, 32'h0,    1,1);
        vecs[19] = mk(0,0,1'b0, 32'h0,  32'h0,    32'h60, BUSY,   32'h0,        0,0, 32'h0,  32'h0,    1,1);
        vecs[20] = mk(0,0,1'b0, 32'h0,  32'h0,    32'h0,  ACCESS, 32'h0,        0,0, 32'h0,  32'h0,    1,1);

        nRST = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
        #2;
        chk_idle("reset");
        @(posedge CLK); #1;
        nRST = 1'b1;

        for (int k = 0; k < NV; k++) begin
            string t;
            t = $sformatf("v%0d", k);
            drive(vecs[k].dr, vecs[k].dw, vecs[k].ir, vecs[k].da, vecs[k].ds,
                  vecs[k].ia, vecs[k].rs, vecs[k].rl);
            @(negedge CLK);
            chk({t, ".ramREN"},   {31'd0, ramREN}, {31'd0, vecs[k].e_ren});
            chk({t, ".ramWEN"},   {31'd0, ramWEN}, {31'd0, vecs[k].e_wen});
            chk({t, ".ramaddr"},  ramaddr,  vecs[k].e_addr);
            chk({t, ".ramstore"}, ramstore, vecs[k].e_store);
            chk({t, ".dwait"},    {31'd0, dwait}, {31'd0, vecs[k].e_dwait});
            chk({t, ".iwait"},    {31'd0, iwait}, {31'd0, vecs[k].e_iwait});
            chk({t, ".dload"},    dload, vecs[k].rl);
            chk({t, ".iload"},    iload, vecs[k].rl);
            @(posedge CLK); #1;
        end

        // Dcache streams single-cycle beats while the icache keeps asking.
        icomp = 0;
        dcomp = 0;
        for (int k = 0; k < 10; k++) begin
            string t;
            t = $sformatf("stream%0d", k);
`ifdef MEM_ARB_FAIR_EN
            exp_i = ((k % 5) == 4);
`else
            exp_i = 1'b0;
`endif
            drive(1, 0, 1, 32'h200, 32'h0, 32'h80, ACCESS, 32'h0);
            @(negedge CLK);
            chk({t, ".ramaddr"}, ramaddr, exp_i ? 32'h80 : 32'h200);
            chk({t, ".iwait"},   {31'd0, iwait}, {31'd0, ~exp_i});
            chk({t, ".dwait"},   {31'd0, dwait}, {31'd0, exp_i});
            if (!iwait) icomp++;
            if (!dwait) dcomp++;
            @(posedge CLK); #1;
        end
`ifdef MEM_ARB_FAIR_EN
        chk("stream.icache_beats", icomp, 32'd2);
        chk("stream.dcache_beats", dcomp, 32'd8);
`else
        chk("stream.icache_beats", icomp, 32'd0);
        chk("stream.dcache_beats", dcomp, 32'd10);
`endif
        drive(0, 0, 1, 32'h200, 32'h0, 32'h80, ACCESS, 32'h0);
        @(negedge CLK);
        chk("stream_end.ramaddr", ramaddr, 32'h80);
        chk("stream_end.iwait",   {31'd0, iwait}, 32'd0);
        @(posedge CLK); #1;

        // Asynchronous reset pulls an icache owner back to IDLE without a clock edge.
        drive(0, 0, 1, 32'h300, 32'h0, 32'h90, BUSY, 32'h0);
        @(posedge CLK); #1;
        drive(1, 0, 1, 32'h300, 32'h0, 32'h90, BUSY, 32'h0);
        #1;
        chk("locked.ramaddr", ramaddr, 32'h90);
        nRST = 1'b0;
        #1;
        chk("async_rst.ramaddr", ramaddr, 32'h300);
        chk("async_rst.ramREN",  {31'd0, ramREN}, 32'd1);
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, FREE, 32'h0);
        #1;
        chk_idle("async_rst.idle");
        nRST = 1'b1;
        @(posedge CLK); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the dcache and icache and upstream of the single-ported RAM.
- Arbitrates word-granular requests from both caches onto the one RAM port and returns wait/load to each cache.
- Grant is locked per beat: once a cache owns the bus, ownership does not switch until that beat completes (ramstate == ACCESS) or the owner drops its request.
- Dcache has fixed priority, so multi-beat dcache sequences (writeback then load) proceed back-to-back.

Parameters:
- WORD_W, 32, data/address width; taken from word_t.
- STARVE_MAX, 4, consecutive dcache beats allowed while the icache waits; used only with MEM_ARB_FAIR_EN.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  0 only in the completing cycle of a dcache beat.
- dload  out  32  read data to dcache.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  0 only in the completing cycle of an icache beat.
- iload  out  32  read data to icache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- States:
  - IDLE: no owner.
  - DOWN: dcache owns the bus.
  - IOWN: icache owns the bus.
- Reset (asynchronous): state = IDLE, starvation counter = 0.
- With no requests (including during reset): ramREN = ramWEN = 0, ramaddr = 0, ramstore = 0, dwait = iwait = 1.
- dload and iload always equal ramload (combinational); caches sample them only when their wait is 0.
- IDLE:
  - Winner = dcache if (dREN | dWEN); else icache if iREN; else none.
  - The winner's request drives the RAM combinationally in the same cycle, giving zero added latency.
  - If ramstate == ACCESS this cycle: the winner's wait = 0 and state stays IDLE.
  - Otherwise: state goes to DOWN or IOWN according to the winner.
- DOWN / IOWN:
  - RAM is driven only by the owner. The other cache sees wait = 1 and its request is ignored.
  - ramstate == ACCESS: owner wait = 0 that cycle; next state = IDLE.
  - Owner deasserts its request: next state = IDLE, no completion, RAM enables drop in the same cycle.
- Signal mapping:
  - Dcache owner: ramWEN = dWEN, ramREN = dREN & ~dWEN. If both are asserted, write wins.
  - Icache owner: ramREN = iREN, ramWEN = 0.
- ramstate BUSY, FREE or ERROR while a request is active: owner wait stays 1 and ownership is held. ERROR is not otherwise handled.
- The beat boundary is the only switch point. A dcache request that arrives mid-icache-beat waits for that beat's ACCESS cycle, then wins the next IDLE arbitration.
- Simultaneous dREN and iREN in IDLE: dcache wins.
- Latency: a beat completes in the first cycle with ramstate == ACCESS, measured from when its request is driven. Arbitration adds no cycles.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- With the macro defined:
  - A counter (width clog2(STARVE_MAX+1)) increments on each completed dcache beat while iREN = 1.
  - It clears to 0 on any icache completion or whenever iREN = 0.
  - When counter == STARVE_MAX, the next IDLE arbitration grants the icache if iREN = 1, even when the dcache is requesting.
- Without the macro: strict dcache priority; no counter is instantiated.

Decomposition:
- cpu_types_pkg supplies word_t and ramstate_t.
- Add arb_state_t (IDLE, DOWN, IOWN) to cpu_types_pkg.
- Sub-module: none required. If split out, the fairness counter becomes mem_arb_starve_ctr, instantiated only under MEM_ARB_FAIR_EN.

Test Plan:
1. Reset, then iREN = 1, iaddr = 0x40, RAM returns BUSY×2 then ACCESS with ramload = 0xDEADBEEF -> ramaddr = 0x40 throughout; iwait = 0 only in the ACCESS cycle, iload = 0xDEADBEEF; dwait = 1 throughout.
2. dREN and iREN asserted in the same cycle (daddr = 0x100, iaddr = 0x0) -> ramaddr = 0x100 first. After the dcache ACCESS, with dREN dropped, the next beat is ramaddr = 0x0 and iwait pulses low once.
3. Icache owns the bus with BUSY; dWEN = 1, daddr = 0x8, dstore = 0x1234 arrives mid-beat -> ramaddr stays iaddr until ACCESS, then ramWEN = 1, ramaddr = 0x8, ramstore = 0x1234.
4. dREN and dWEN both 1 -> ramWEN = 1, ramREN = 0.
5. Owner drops its request while ramstate = BUSY -> RAM enables go to 0 in the same cycle; next cycle state is IDLE and no wait pulse occurs.
6. MEM_ARB_FAIR_EN, STARVE_MAX = 4: dcache streams beats with iREN held at 1 -> after 4 dcache completions the icache is granted once; without the macro the icache never completes until dcache requests stop.
